// File: rtl/output_display_if.sv
// Bus-side interface of the output display block: load strobe, bus byte,
// mode bits and the captured-value/busy status returned to the CPU side.
// Optional macro OUTPUT_HEX_MODE_EN adds the hex_mode signal.
interface output_display_if;
  logic       read_from_bus;
  logic [7:0] bus;
  logic       signed_mode;
`ifdef OUTPUT_HEX_MODE_EN
  logic       hex_mode;
`endif
  logic [7:0] value;
  logic       busy;

`ifdef OUTPUT_HEX_MODE_EN
  modport master (output read_from_bus, bus, signed_mode, hex_mode,
                  input  value, busy);
  modport slave  (input  read_from_bus, bus, signed_mode, hex_mode,
                  output value, busy);
`else
  modport master (output read_from_bus, bus, signed_mode,
                  input  value, busy);
  modport slave  (input  read_from_bus, bus, signed_mode,
                  output value, busy);
`endif
endinterface

// File: rtl/output_display.sv
// CPU output stage: captures a bus byte on read_from_bus, converts it to
// decimal (unsigned or two's complement) with a sequential double-dabble
// engine and drives a 4-digit multiplexed 7-segment display.
// Optional macro OUTPUT_HEX_MODE_EN adds a hex display mode sampled at load.
module output_display #(
  parameter int unsigned REFRESH_DIV = 27000
) (
  input  logic              clk,
  input  logic              rst_n,
  output_display_if.slave   bus_if,
  output logic [6:0]        seg,
  output logic [3:0]        digit_sel
);

  typedef enum logic [1:0] {IDLE, PREP, SHIFT, LATCH} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  state_t           state_q, state_d;
  logic [7:0]       value_q, value_d;
  logic             sgn_q, sgn_d;
  logic             hex_q, hex_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [8:0]       mag_q, mag_d;
  logic             neg_q, neg_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [11:0]      adj;
  logic [2:0][3:0]  disp_q, disp_d;
  logic             dneg_q, dneg_d;
  logic             dhex_q, dhex_d;
  logic [15:0]      ref_cnt_q, ref_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       sel_q, sel_d;
  logic             hex_in;

`ifdef OUTPUT_HEX_MODE_EN
  assign hex_in = bus_if.hex_mode;
`else
  assign hex_in = 1'b0;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  // Conversion FSM: load restarts from any state, PREP/SHIFT/LATCH build and publish digits
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    sgn_d   = sgn_q;
    hex_d   = hex_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    dneg_d  = dneg_q;
    dhex_d  = dhex_q;
    adj     = bcd_q;
    case (state_q)
      PREP: begin
        if (sgn_q && value_q[7]) begin
          mag_d = 9'd256 - {1'b0, value_q};
          neg_d = 1'b1;
        end else begin
          mag_d = {1'b0, value_q};
          neg_d = 1'b0;
        end
        bcd_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < 3; i++) begin
          if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        // magnitude never exceeds 255, so bit 7 is the next bit to feed in
        bcd_d = (adj << 1) | {11'd0, mag_q[7]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = LATCH;
      end
      LATCH: begin
        if (hex_q) begin
          disp_d[0] = value_q[3:0];
          disp_d[1] = value_q[7:4];
          disp_d[2] = 4'd0;
          dneg_d    = 1'b0;
          dhex_d    = 1'b1;
        end else begin
          disp_d[0] = bcd_q[3:0];
          disp_d[1] = bcd_q[7:4];
          disp_d[2] = bcd_q[11:8];
          dneg_d    = neg_q;
          dhex_d    = 1'b0;
        end
        state_d = IDLE;
      end
      default: ;
    endcase
    if (bus_if.read_from_bus) begin
      value_d = bus_if.bus;
      sgn_d   = bus_if.signed_mode;
      hex_d   = hex_in;
      cnt_d   = 3'd0;
      state_d = PREP;
    end
  end

  // Refresh scan and registered glyph/select; select is built from the next
  // index so digit_sel changes exactly every REFRESH_DIV cycles
  always_comb begin
    ref_cnt_d = ref_cnt_q + 16'd1;
    idx_d     = idx_q;
    if (ref_cnt_q == 16'(REFRESH_DIV - 1)) begin
      ref_cnt_d = 16'd0;
      idx_d     = idx_q + 2'd1;
    end
    sel_d = 4'b0001 << idx_d;
    seg_d = SEG_BLANK;
    case (idx_d)
      2'd0: seg_d = glyph(disp_q[0]);
      2'd1: if (dhex_q || disp_q[2] != 4'd0 || disp_q[1] != 4'd0) seg_d = glyph(disp_q[1]);
      2'd2: if (!dhex_q && disp_q[2] != 4'd0) seg_d = glyph(disp_q[2]);
      default: if (dneg_q) seg_d = SEG_MINUS;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      value_q   <= '0;
      sgn_q     <= 1'b0;
      hex_q     <= 1'b0;
      cnt_q     <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      disp_q    <= '0;
      dneg_q    <= 1'b0;
      dhex_q    <= 1'b0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= 7'b0111111;
      sel_q     <= 4'b0001;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      sgn_q     <= sgn_d;
      hex_q     <= hex_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      disp_q    <= disp_d;
      dneg_q    <= dneg_d;
      dhex_q    <= dhex_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
    end
  end

  assign bus_if.value = value_q;
  assign bus_if.busy  = (state_q != IDLE);
  assign seg          = seg_q;
  assign digit_sel    = sel_q;

endmodule
